// File: rtl/aqed_dup_sched_if.sv
// Handshake bundle between the A-QED duplicate-check sequencer and its environment.
// master = sequencer side, slave = stimulus source / wrapper / core side.
interface aqed_dup_sched_if #(
    parameter int GAP_W = 8
);
    logic             clk_en;
    logic             start;
    logic             clear;
    logic [GAP_W-1:0] gap_cfg;
    logic             in_valid;
    logic             full;
    logic             empty;
    logic             qed_done;
    logic             qed_check;
    logic             in_ready;
    logic             wen;
    logic             ren;
    logic             exec_dup;
    logic             flush;
    logic             rearm;
    logic             busy;
    logic             pass;
    logic             fail;
    logic             timeout;
    logic [2:0]       state;

    modport master (
        input  clk_en, start, clear, gap_cfg, in_valid, full, empty, qed_done, qed_check,
        output in_ready, wen, ren, exec_dup, flush, rearm, busy, pass, fail, timeout, state
    );

    modport slave (
        output clk_en, start, clear, gap_cfg, in_valid, full, empty, qed_done, qed_check,
        input  in_ready, wen, ren, exec_dup, flush, rearm, busy, pass, fail, timeout, state
    );
endinterface

// File: rtl/aqed_dup_sched.sv
// Sequences one A-QED duplicate check: orig write, gap_cfg filler writes, dup write,
// then drains the core until the wrapper reports qed_done or the watchdog expires.
module aqed_dup_sched #(
    parameter int GAP_W   = 8,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    aqed_dup_sched_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ORIG  = 3'd1,
        S_GAP   = 3'd2,
        S_DUP   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5,
        S_FLUSH = 3'd6
    } state_t;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

    state_t           state_q;
    state_t           state_nxt;
    logic [GAP_W-1:0] gap_reg;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_inc;
    logic [TO_W-1:0]  wd_cnt;
    logic             pass_q;
    logic             fail_q;
    logic             timeout_q;
    logic             wr_phase;
    logic             fire;

    assign wr_phase = (state_q == S_ORIG) || (state_q == S_GAP) || (state_q == S_DUP);
    assign fire     = bus.clk_en & bus.in_valid & ~bus.full & wr_phase;
    assign gap_inc  = gap_cnt + GAP_W'(1);

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_nxt = S_ORIG;
            S_ORIG:  if (fire) state_nxt = (gap_reg == '0) ? S_DUP : S_GAP;
            S_GAP:   if (fire && (gap_inc == gap_reg)) state_nxt = S_DUP;
            S_DUP:   if (fire) state_nxt = S_DRAIN;
            S_DRAIN: if (bus.qed_done || (wd_cnt == WD_LAST)) state_nxt = S_DONE;
            S_DONE:  if (bus.clear) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            gap_reg   <= '0;
            gap_cnt   <= '0;
            wd_cnt    <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else if (bus.clk_en) begin
            state_q <= state_nxt;
            case (state_q)
                S_IDLE: if (bus.start) begin
                    gap_reg   <= bus.gap_cfg;
                    gap_cnt   <= '0;
                    wd_cnt    <= '0;
                    pass_q    <= 1'b0;
                    fail_q    <= 1'b0;
                    timeout_q <= 1'b0;
                end
                S_ORIG: if (fire) gap_cnt <= '0;
                S_GAP:  if (fire) gap_cnt <= gap_inc;
                S_DUP:  if (fire) wd_cnt <= '0;
                S_DRAIN: begin
                    wd_cnt <= wd_cnt + TO_W'(1);
                    // a completed check outranks a watchdog expiring in the same cycle
                    if (bus.qed_done) begin
                        pass_q <= bus.qed_check;
                        fail_q <= ~bus.qed_check;
                    end else if (wd_cnt == WD_LAST) begin
                        timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.wen      = fire;
    assign bus.in_ready = fire;
    assign bus.ren      = bus.clk_en & ~bus.empty & (state_q == S_DRAIN);
    assign bus.exec_dup = (state_q == S_ORIG) || (state_q == S_DUP);
    // flush/rearm gated by clk_en so the pulse spans exactly one enabled cycle
    assign bus.flush    = bus.clk_en & (state_q == S_FLUSH);
    assign bus.rearm    = bus.clk_en & (state_q == S_FLUSH);
    assign bus.busy     = wr_phase || (state_q == S_DRAIN) || (state_q == S_FLUSH);
    assign bus.pass     = pass_q;
    assign bus.fail     = fail_q;
    assign bus.timeout  = timeout_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_aqed_dup_sched.sv
// Self-checking bench for aqed_dup_sched: table of check scenarios plus hand-written reset/clock-enable sequences.
module tb_aqed_dup_sched;
    localparam int GAP_W   = 8;
    localparam int TIMEOUT = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    aqed_dup_sched_if #(.GAP_W(GAP_W)) bus ();

    aqed_dup_sched #(.GAP_W(GAP_W), .TIMEOUT(TIMEOUT), .TO_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int       gap;
        bit       corrupt;
        bit       no_done;
        int       stall_at;
        int       stall_len;
        bit [2:0] exp_v;     // {pass, fail, timeout}
    } vec_t;

    vec_t     vecs[6];
    bit       edq[$];
    bit [2:0] vq[$];
    int       n_checks = 0;
    int       n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    function automatic int out_vec();
        return int'({bus.in_ready, bus.wen, bus.ren, bus.exec_dup, bus.flush, bus.rearm,
                     bus.busy, bus.pass, bus.fail, bus.timeout, bus.state});
    endfunction

    task automatic run_check(input vec_t v);
        int  writes = 0, drain = 0, first_w = -1, last_w = -1, saw_gap = 0;
        int  stall_left = v.stall_len;
        bit  done = 1'b0;
        bit [2:0] vexp;
        edq.push_back(1'b1);
        for (int i = 0; i < v.gap; i++) edq.push_back(1'b0);
        edq.push_back(1'b1);
        vq.push_back(v.exp_v);

        @(negedge clk);
        bus.gap_cfg = GAP_W'(v.gap); bus.start = 1'b1; bus.in_valid = 1'b1; bus.full = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            bus.full = (writes == v.stall_at) && (stall_left > 0) && (bus.state == 3'd2);
            if (bus.full) stall_left--;
            bus.empty     = 1'($urandom_range(0, 1));
            bus.qed_done  = (bus.state == 3'd4) && (drain == 3) && !v.no_done;
            bus.qed_check = !v.corrupt;
            #1;
            if (bus.state == 3'd2) saw_gap = 1;
            if (bus.full) begin
                chk("stall_wen", bus.wen, 0);
                chk("stall_exec_dup", bus.exec_dup, 0);
            end
            if (bus.state == 3'd4) begin
                chk("drain_ren", bus.ren, !bus.empty);
                chk("drain_wen", bus.wen, 0);
                drain++;
            end
            if (bus.wen) begin
                chk("in_ready", bus.in_ready, 1);
                if (edq.size() == 0) chk("extra_write", 1, 0);
                else chk("exec_dup", bus.exec_dup, edq.pop_front());
                if (first_w < 0) first_w = cyc;
                last_w = cyc;
                writes++;
            end
            if (bus.state == 3'd5) done = 1'b1;
            else @(negedge clk);
        end
        bus.qed_done = 1'b0;
        if (!done) begin
            chk("done_bound", 0, 1);
            edq.delete(); vq.delete();
            return;
        end
        vexp = vq.pop_front();
        chk("verdict", {bus.pass, bus.fail, bus.timeout}, vexp);
        chk("write_count", writes, v.gap + 2);
        chk("missing_writes", edq.size(), 0);
        edq.delete();
        chk("gap_visited", saw_gap, (v.gap != 0) ? 1 : 0);
        chk("drain_cycles", drain, v.no_done ? TIMEOUT : 4);
        chk("done_busy", bus.busy, 0);
        if (v.stall_len == 0) chk("consecutive_writes", last_w - first_w, v.gap + 1);

        // start is ignored in DONE; clear moves to a one-cycle FLUSH then IDLE
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0; #1;
        chk("done_ignores_start", bus.state, 5);
        @(negedge clk); bus.clear = 1'b1;
        @(negedge clk); bus.clear = 1'b0; #1;
        chk("flush_state", bus.state, 6);
        chk("flush_pulse", {bus.flush, bus.rearm, bus.busy}, 3'b111);
        @(negedge clk); #1;
        chk("idle_after_flush", bus.state, 0);
        chk("flush_ends", {bus.flush, bus.rearm}, 2'b00);
        chk("verdict_kept", {bus.pass, bus.fail, bus.timeout}, vexp);
    endtask

    initial begin
        vecs[0] = '{gap: 3,   corrupt: 0, no_done: 0, stall_at: 0, stall_len: 0, exp_v: 3'b100};
        vecs[1] = '{gap: 0,   corrupt: 0, no_done: 0, stall_at: 0, stall_len: 0, exp_v: 3'b100};
        vecs[2] = '{gap: 2,   corrupt: 0, no_done: 0, stall_at: 2, stall_len: 4, exp_v: 3'b100};
        vecs[3] = '{gap: 1,   corrupt: 1, no_done: 0, stall_at: 0, stall_len: 0, exp_v: 3'b010};
        vecs[4] = '{gap: 2,   corrupt: 0, no_done: 1, stall_at: 0, stall_len: 0, exp_v: 3'b001};
        vecs[5] = '{gap: 255, corrupt: 0, no_done: 0, stall_at: 0, stall_len: 0, exp_v: 3'b100};

        bus.clk_en = 1'b1; bus.start = 1'b0; bus.clear = 1'b0; bus.gap_cfg = '0;
        bus.in_valid = 1'b0; bus.full = 1'b0; bus.empty = 1'b1;
        bus.qed_done = 1'b0; bus.qed_check = 1'b0;
        #2 reset = 1'b1;
        #1 chk("reset_outputs", out_vec(), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1 chk("post_reset_state", bus.state, 0);

        for (int i = 0; i < 6; i++) run_check(vecs[i]);

        // clock-enable freeze mid-GAP, then asynchronous reset mid-GAP
        @(negedge clk);
        bus.gap_cfg = 8'd4; bus.start = 1'b1; bus.in_valid = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); #1;
        chk("gap_entry", bus.state, 2);
        bus.clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("frozen_wen", bus.wen, 0);
            chk("frozen_state", bus.state, 2);
            @(negedge clk);
        end
        bus.clk_en = 1'b1; #1;
        chk("unfrozen_wen", bus.wen, 1);
        @(negedge clk); #1;
        chk("still_gap", bus.state, 2);
        reset = 1'b1; #1;
        chk("async_reset_outputs", out_vec(), 0);
        @(negedge clk);
        reset = 1'b0; bus.in_valid = 1'b0; #1;
        chk("idle_after_reset", bus.state, 0);
        @(negedge clk); #1;
        chk("no_restart", bus.state, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
